// File: rtl/gpio_pin_change_irq.sv
// ---------------------------------------------------------------------------
// gpio_pin_change_irq
//
// Input side of a GPIO port. It synchronises the raw pin levels and debounces
// them, and it raises a level interrupt when a masked pin changes state.
// Software sees the clean levels through the PIN register and through pin_val.
//
// Register map (bus_addr):
//   0 PIN   RO   debounced pin levels (writes ignored)
//   1 MASK  RW   per-pin change enable
//   2 FLAG  W1C  per-pin change flag
//   3 CTRL  RW   bit0 = IE, other bits read 0
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   pin_in     raw external pin levels, asynchronous to clk
//   bus_addr   register select
//   bus_wdata  write data
//   bus_we     write strobe, one cycle per access
//   bus_re     read strobe, one cycle per access
//   bus_rdata  registered read data, held until the next read
//   pin_val    debounced pin levels
//   irq        interrupt request, CTRL.IE & |FLAG
// ---------------------------------------------------------------------------
module gpio_pin_change_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [1:0]       bus_addr,
    input  logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_we,
    input  logic             bus_re,
    output logic [WIDTH-1:0] bus_rdata,
    output logic [WIDTH-1:0] pin_val,
    output logic             irq
);

    localparam int            CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    localparam logic [1:0] ADDR_PIN  = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_FLAG = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;

    logic [WIDTH-1:0]         deb_q, deb_d;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]         chg;

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] flag_q, flag_d;
    logic             ctrl_ie_q, ctrl_ie_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [WIDTH-1:0] flag_clr;
    logic [WIDTH-1:0] rd_sel;

    // Synchroniser chain. Stage 0 samples the asynchronous pins directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Debounce. A pin's synced level must differ from its accepted level for
    // DEBOUNCE consecutive cycles. The cycle that accepts the new level also
    // emits a one-cycle change pulse. Any cycle with the levels equal restarts
    // the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        chg   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync[i];
                    chg[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Bus register next-state.
    always_comb begin
        mask_d    = mask_q;
        ctrl_ie_d = ctrl_ie_q;
        flag_clr  = '0;
        rdata_d   = rdata_q;

        if (bus_we) begin
            case (bus_addr)
                ADDR_MASK: mask_d    = bus_wdata;
                ADDR_FLAG: flag_clr  = bus_wdata;
                ADDR_CTRL: ctrl_ie_d = bus_wdata[0];
                default:   ;
            endcase
        end

        // The clear is applied before the set, so a new change on the same
        // edge as a clear wins and the flag stays up.
        flag_d = (flag_q & ~flag_clr) | (chg & mask_q);

        // The read captures the registers before this edge. A write in the
        // same cycle reads back the old value.
        case (bus_addr)
            ADDR_PIN:  rd_sel = deb_q;
            ADDR_MASK: rd_sel = mask_q;
            ADDR_FLAG: rd_sel = flag_q;
            default:   rd_sel = WIDTH'(ctrl_ie_q);
        endcase
        if (bus_re) begin
            rdata_d = rd_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q     <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            flag_q    <= '0;
            ctrl_ie_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            flag_q    <= flag_d;
            ctrl_ie_q <= ctrl_ie_d;
            rdata_q   <= rdata_d;
        end
    end

    assign pin_val   = deb_q;
    assign bus_rdata = rdata_q;
    assign irq       = ctrl_ie_q & (|flag_q);

endmodule

// File: tb/tb_gpio_pin_change_irq.sv
module tb_gpio_pin_change_irq;

    logic       clk;
    logic       rst;
    logic [7:0] pin_in;
    logic [1:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata;
    logic [7:0] pin_val;
    logic       irq;

    int tests;
    int fails;

    gpio_pin_change_irq #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .DEBOUNCE   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pin_in   (pin_in),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_rdata(bus_rdata),
        .pin_val  (pin_val),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: return 1 ns after the rising edge. All driving and sampling
    // happens at that point, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        step();
        bus_we    = 1'b0;
        bus_wdata = 8'h00;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_re   = 1'b1;
        step();
        bus_re   = 1'b0;
        d        = bus_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1;
        step();
        step();
        tests++; if (pin_val !== 8'h00) begin fails++; $display("FAIL reset_pin_val: got %h expected 00", pin_val); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
        tests++; if (bus_rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h expected 00", bus_rdata); end
        rst = 1'b0;
        step();
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL reset_flag: got %h expected 00", rd); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL reset_mask: got %h expected 00", rd); end
    endtask

    task automatic test_rise_latency();
        logic [7:0] rd;
        bus_write(2'd1, 8'h01);
        bus_write(2'd3, 8'h01);
        bus_read(2'd1, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL mask_readback: got %h expected 01", rd); end
        bus_read(2'd3, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL ctrl_readback: got %h expected 01", rd); end
        pin_in = 8'h01;
        repeat (5) step();
        tests++; if (pin_val !== 8'h00) begin fails++; $display("FAIL rise_early_pin_val: got %h expected 00", pin_val); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rise_early_irq: got %b expected 0", irq); end
        step();
        tests++; if (pin_val !== 8'h01) begin fails++; $display("FAIL rise_pin_val: got %h expected 01", pin_val); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL rise_irq: got %b expected 1", irq); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL rise_flag: got %h expected 01", rd); end
    endtask

    task automatic test_fall();
        logic [7:0] rd;
        bus_write(2'd2, 8'h01);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL w1c_irq: got %b expected 0", irq); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL w1c_flag: got %h expected 00", rd); end
        pin_in = 8'h00;
        repeat (5) step();
        tests++; if (pin_val !== 8'h01) begin fails++; $display("FAIL fall_early_pin_val: got %h expected 01", pin_val); end
        step();
        tests++; if (pin_val !== 8'h00) begin fails++; $display("FAIL fall_pin_val: got %h expected 00", pin_val); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL fall_irq: got %b expected 1", irq); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL fall_flag: got %h expected 01", rd); end
        bus_write(2'd2, 8'h01);
    endtask

    task automatic test_glitch();
        logic [7:0] rd;
        bus_write(2'd1, 8'h08);
        pin_in = 8'h08;
        repeat (3) step();
        pin_in = 8'h00;
        repeat (10) step();
        tests++; if (pin_val !== 8'h00) begin fails++; $display("FAIL glitch_pin_val: got %h expected 00", pin_val); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL glitch_irq: got %b expected 0", irq); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL glitch_flag: got %h expected 00", rd); end
        pin_in = 8'h08;
        repeat (5) step();
        pin_in = 8'h00;
        step();
        tests++; if (pin_val !== 8'h08) begin fails++; $display("FAIL pulse5_pin_val: got %h expected 08", pin_val); end
        repeat (12) step();
        tests++; if (pin_val !== 8'h00) begin fails++; $display("FAIL pulse5_return: got %h expected 00", pin_val); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h08) begin fails++; $display("FAIL pulse5_flag: got %h expected 08", rd); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL pulse5_irq: got %b expected 1", irq); end
        bus_write(2'd2, 8'h08);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL pulse5_clear_irq: got %b expected 0", irq); end
    endtask

    task automatic test_mask_ie();
        logic [7:0] rd;
        bus_write(2'd1, 8'h00);
        pin_in = 8'hFF;
        repeat (8) step();
        tests++; if (pin_val !== 8'hFF) begin fails++; $display("FAIL unmasked_pin_val: got %h expected ff", pin_val); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL unmasked_irq: got %b expected 0", irq); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL unmasked_flag: got %h expected 00", rd); end
        bus_write(2'd0, 8'h00);
        bus_read(2'd0, rd);
        tests++; if (rd !== 8'hFF) begin fails++; $display("FAIL pin_ro: got %h expected ff", rd); end
        bus_write(2'd3, 8'h00);
        bus_write(2'd1, 8'h02);
        pin_in = 8'hFD;
        repeat (8) step();
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h02) begin fails++; $display("FAIL ie0_flag: got %h expected 02", rd); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL ie0_irq: got %b expected 0", irq); end
        bus_write(2'd3, 8'hFF);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL ie1_irq: got %b expected 1", irq); end
        bus_read(2'd3, rd);
        tests++; if (rd !== 8'h01) begin fails++; $display("FAIL ctrl_upper_zero: got %h expected 01", rd); end
        bus_write(2'd1, 8'h00);
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h02) begin fails++; $display("FAIL mask_clear_keeps_flag: got %h expected 02", rd); end
        bus_write(2'd1, 8'h02);
        bus_write(2'd2, 8'h02);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL ie1_clear_irq: got %b expected 0", irq); end
    endtask

    task automatic test_set_clear_collide();
        logic [7:0] rd;
        pin_in = 8'hFF;
        repeat (5) step();
        tests++; if (pin_val !== 8'hFD) begin fails++; $display("FAIL collide_pre_pin_val: got %h expected fd", pin_val); end
        bus_addr  = 2'd2;
        bus_wdata = 8'h02;
        bus_we    = 1'b1;
        step();
        bus_we    = 1'b0;
        bus_wdata = 8'h00;
        tests++; if (pin_val !== 8'hFF) begin fails++; $display("FAIL collide_pin_val: got %h expected ff", pin_val); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL collide_irq: got %b expected 1", irq); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h02) begin fails++; $display("FAIL collide_flag: got %h expected 02", rd); end
    endtask

    task automatic test_back_to_back_rw();
        logic [7:0] rd;
        bus_addr  = 2'd2;
        bus_wdata = 8'h02;
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        step();
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_wdata = 8'h00;
        tests++; if (bus_rdata !== 8'h02) begin fails++; $display("FAIL rw_prewrite: got %h expected 02", bus_rdata); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rw_irq: got %b expected 0", irq); end
        repeat (3) step();
        tests++; if (bus_rdata !== 8'h02) begin fails++; $display("FAIL rdata_hold: got %h expected 02", bus_rdata); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL rw_postwrite: got %h expected 00", rd); end
    endtask

    task automatic test_reset_mid_debounce();
        logic [7:0] rd;
        bus_write(2'd1, 8'h01);
        pin_in = 8'hFE;
        repeat (6) step();
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL prerst_irq: got %b expected 1", irq); end
        bus_read(2'd0, rd);
        tests++; if (rd !== 8'hFE) begin fails++; $display("FAIL prerst_pin: got %h expected fe", rd); end
        pin_in = 8'hFF;
        repeat (4) step();
        #2;
        rst = 1'b1;
        #1;
        tests++; if (pin_val !== 8'h00) begin fails++; $display("FAIL midrst_pin_val: got %h expected 00", pin_val); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        tests++; if (bus_rdata !== 8'h00) begin fails++; $display("FAIL midrst_rdata: got %h expected 00", bus_rdata); end
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        tests++; if (pin_val !== 8'hFF) begin fails++; $display("FAIL postrst_pin_val: got %h expected ff", pin_val); end
        bus_read(2'd2, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL postrst_flag: got %h expected 00", rd); end
        bus_read(2'd1, rd);
        tests++; if (rd !== 8'h00) begin fails++; $display("FAIL postrst_mask: got %h expected 00", rd); end
        bus_write(2'd3, 8'h01);
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL postrst_irq: got %b expected 0", irq); end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        pin_in    = 8'h00;
        bus_addr  = 2'd0;
        bus_wdata = 8'h00;
        bus_we    = 1'b0;
        bus_re    = 1'b0;

        test_reset();
        test_rise_latency();
        test_fall();
        test_glitch();
        test_mask_ie();
        test_set_clear_collide();
        test_back_to_back_rw();
        test_reset_mid_debounce();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
